// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, issues in-order word reads, buffers responses in a ring.
// Optional misaligned-redirect trap is enabled by defining INST_FETCH_MISALIGN_TRAP_EN.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        inst_valid,
  output logic        misalign
);

  localparam int          AW  = $clog2(DEPTH);
  localparam int          CW  = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]      pc_reg;
  logic [AW-1:0]    alloc_ptr_reg;
  logic [AW-1:0]    fill_ptr_reg;
  logic [AW-1:0]    head_ptr_reg;
  logic [CW-1:0]    used_reg;
  logic [CW-1:0]    pend_reg;
  logic [CW-1:0]    drop_reg;
  logic [DEPTH-1:0] filled_reg;
  logic             misalign_reg;
  logic [31:0]      instr_reg;
  logic [31:0]      pc_out_reg;
  logic             valid_reg;

  logic [31:0] ring_pc   [DEPTH];
  logic [31:0] ring_data [DEPTH];

  logic        req_fire;
  logic        rsp_drop;
  logic        rsp_fill;
  logic        pop;
  logic        trap;
  logic [31:0] target_pc;
  logic [CW:0] occupancy;

  assign occupancy      = {1'b0, used_reg} + {1'b0, drop_reg};
  assign imem_req_valid = !rst && !redirect && !misalign_reg && (occupancy < (CW+1)'(DEPTH));
  assign imem_addr      = pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // pend_reg counts allocated-but-unfilled entries; responses with nothing pending are ignored
  assign rsp_drop = imem_rsp_valid && (drop_reg != '0);
  assign rsp_fill = imem_rsp_valid && (drop_reg == '0) && (pend_reg != '0);
  assign pop      = !stall && filled_reg[head_ptr_reg];

`ifdef INST_FETCH_MISALIGN_TRAP_EN
  assign trap      = (redirect_pc[1:0] != 2'b00);
  assign target_pc = redirect_pc;
`else
  assign trap      = 1'b0;
  assign target_pc = redirect_pc & ~32'h0000_0003;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg        <= RESET_PC;
      alloc_ptr_reg <= '0;
      fill_ptr_reg  <= '0;
      head_ptr_reg  <= '0;
      used_reg      <= '0;
      pend_reg      <= '0;
      drop_reg      <= '0;
      misalign_reg  <= 1'b0;
      instr_reg     <= NOP;
      pc_out_reg    <= '0;
      valid_reg     <= 1'b0;
    end else if (redirect) begin
      // Everything still in flight becomes stale, including a response landing this cycle
      drop_reg      <= drop_reg + pend_reg - CW'(rsp_drop | rsp_fill);
      pc_reg        <= target_pc;
      alloc_ptr_reg <= '0;
      fill_ptr_reg  <= '0;
      head_ptr_reg  <= '0;
      used_reg      <= '0;
      pend_reg      <= '0;
      instr_reg     <= NOP;
      valid_reg     <= 1'b0;
      if (trap) begin
        misalign_reg <= 1'b1;
        pc_out_reg   <= redirect_pc;
      end
    end else begin
      if (req_fire) begin
        pc_reg        <= pc_reg + 32'd4;
        alloc_ptr_reg <= alloc_ptr_reg + AW'(1);
      end
      if (rsp_drop) drop_reg <= drop_reg - CW'(1);
      if (rsp_fill) fill_ptr_reg <= fill_ptr_reg + AW'(1);
      used_reg <= used_reg + CW'(req_fire) - CW'(pop);
      pend_reg <= pend_reg + CW'(req_fire) - CW'(rsp_fill);
      if (!stall) begin
        if (filled_reg[head_ptr_reg]) begin
          instr_reg    <= ring_data[head_ptr_reg];
          pc_out_reg   <= ring_pc[head_ptr_reg];
          valid_reg    <= 1'b1;
          head_ptr_reg <= head_ptr_reg + AW'(1);
        end else begin
          instr_reg <= NOP;
          valid_reg <= 1'b0;
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_filled
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          filled_reg[gi] <= 1'b0;
        end else if (redirect) begin
          filled_reg[gi] <= 1'b0;
        end else if (rsp_fill && fill_ptr_reg == AW'(gi)) begin
          filled_reg[gi] <= 1'b1;
        end else if (pop && head_ptr_reg == AW'(gi)) begin
          filled_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // Payload storage needs no reset: filled_reg guards every read
  always_ff @(posedge clk) begin
    if (req_fire) ring_pc[alloc_ptr_reg] <= pc_reg;
    if (rsp_fill && !redirect) ring_data[fill_ptr_reg] <= imem_rsp_data;
  end

  assign instruction = instr_reg;
  assign pc_out      = pc_out_reg;
  assign inst_valid  = valid_reg;
  assign misalign    = misalign_reg;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: in-order memory with per-request latency and a queue-based reference model.
module tb_inst_fetch;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        inst_valid;
  logic        misalign;

  inst_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .instruction(instruction), .pc_out(pc_out), .inst_valid(inst_valid), .misalign(misalign)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // memory: in-order queue of accepted requests with due cycle
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];
  int lat       = 1;
  int slow_left = 0;
  int blocked   = 0;

  // reference model
  logic [31:0] m_pc, m_instr, m_pcout;
  logic        m_valid, m_mis;
  int          m_drop;
  logic [31:0] pend_q[$];
  logic [31:0] rq_pc[$];
  logic [31:0] rq_data[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[23:0], 8'h93};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = NOP; m_pcout = 32'h0; m_valid = 1'b0; m_mis = 1'b0; m_drop = 0;
    pend_q.delete(); rq_pc.delete(); rq_data.delete();
  endtask

  // one clock cycle: drive memory response, compare outputs, update environment and model
  task automatic step();
    logic        rv;
    logic [31:0] rd;
    logic        m_req;
    bit          consumed;
    int          l;
    rv = 1'b0; rd = 32'h0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      rv = 1'b1; rd = mem_word(mq[0].addr);
    end
    imem_rsp_valid = rv;
    imem_rsp_data  = rd;
    #1;
    m_req = !redirect && !m_mis && (pend_q.size() + rq_pc.size() + m_drop < DEPTH);
    chk("req_valid",   imem_req_valid, m_req);
    chk("imem_addr",   imem_addr, m_pc);
    chk("instruction", instruction, m_instr);
    chk("pc_out",      pc_out, m_pcout);
    chk("inst_valid",  inst_valid, m_valid);
    chk("misalign",    misalign, m_mis);
    chk("outstanding_le_depth", mq.size() <= DEPTH, 1);
    if (!imem_req_valid) blocked++;

    if (rv) void'(mq.pop_front());
    if (imem_req_valid && imem_req_ready) begin
      if (slow_left > 0) begin l = 5; slow_left--; end else l = lat;
      mq.push_back('{addr: imem_addr, due: cyc + l});
    end

    if (redirect) begin
      consumed = rv && (m_drop > 0 || pend_q.size() > 0);
      m_drop = m_drop + pend_q.size() - (consumed ? 1 : 0);
      pend_q.delete(); rq_pc.delete(); rq_data.delete();
      m_instr = NOP; m_valid = 1'b0;
`ifdef INST_FETCH_MISALIGN_TRAP_EN
      if (redirect_pc[1:0] != 2'b00) begin m_mis = 1'b1; m_pcout = redirect_pc; end
      m_pc = redirect_pc;
`else
      m_pc = redirect_pc & ~32'h3;
`endif
    end else begin
      if (!stall) begin
        if (rq_pc.size() > 0) begin
          m_instr = rq_data.pop_front(); m_pcout = rq_pc.pop_front(); m_valid = 1'b1;
        end else begin
          m_instr = NOP; m_valid = 1'b0;
        end
      end
      if (rv) begin
        if (m_drop > 0) m_drop--;
        else if (pend_q.size() > 0) begin
          rq_pc.push_back(pend_q.pop_front()); rq_data.push_back(rd);
        end
      end
      if (m_req && imem_req_ready) begin
        pend_q.push_back(m_pc); m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    imem_rsp_valid = 1'b0;
    mq.delete();
    model_reset();
    for (int i = 0; i < n; i++) begin
      #1;
      chk("rst_req_valid",  imem_req_valid, 0);
      chk("rst_instruction", instruction, NOP);
      chk("rst_pc_out",     pc_out, 0);
      chk("rst_inst_valid", inst_valid, 0);
      chk("rst_misalign",   misalign, 0);
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp_pc);
    for (int i = 0; i < 20 && !inst_valid; i++) step();
    chk({name, "_arrived"}, inst_valid, 1);
    chk({name, "_pc"}, pc_out, exp_pc);
    chk({name, "_instr"}, instruction, mem_word(exp_pc));
  endtask

  initial begin
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
    @(negedge clk);
    do_reset(3);

    // streaming, latency 1
    imem_req_ready = 1'b1;
    repeat (2) step();
    chk("cyc2_not_valid", inst_valid, 0);
    step();
    chk("first_valid", inst_valid, 1);
    chk("first_pc", pc_out, 32'h0);
    chk("first_instr", instruction, mem_word(32'h0));
    step();
    chk("second_pc", pc_out, 32'h4);
    repeat (8) step();

    // three slow responses
    slow_left = 3; blocked = 0;
    repeat (16) step();
    chk("req_throttled", blocked > 0, 1);

    // stall long enough to fill the ring
    stall = 1'b1;
    repeat (8) step();
    chk("stall_full_noreq", imem_req_valid, 0);
    stall = 1'b0;
    repeat (8) step();

    // redirect with responses in flight at latency 2
    lat = 2;
    repeat (6) step();
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    chk("redir_bubble", inst_valid, 0);
    chk("redir_addr", imem_addr, 32'h100);
    wait_valid("redir", 32'h100);
    lat = 1;
    repeat (4) step();

    // redirect together with stall
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    chk("stall_redir_valid", inst_valid, 0);
    chk("stall_redir_nop", instruction, NOP);
    chk("stall_redir_addr", imem_addr, 32'h100);
    stall = 1'b0;
    repeat (6) step();

    // misaligned redirect target
    redirect = 1'b1; redirect_pc = 32'h102;
    step();
    redirect = 1'b0;
`ifdef INST_FETCH_MISALIGN_TRAP_EN
    repeat (6) step();
    chk("mis_flag", misalign, 1);
    chk("mis_noreq", imem_req_valid, 0);
    chk("mis_nop", inst_valid, 0);
    chk("mis_pc_out", pc_out, 32'h102);
`else
    chk("mis_aligned_addr", imem_addr, 32'h100);
    chk("mis_flag_low", misalign, 0);
    wait_valid("mis", 32'h100);
`endif

    // reset mid-run
    repeat (3) step();
    do_reset(2);
    repeat (3) step();
    chk("rerun_valid", inst_valid, 1);
    chk("rerun_pc", pc_out, 32'h0);
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
